sifir_sayici_denetleyici: RTL and testbench
===========================================

Name: sifir_sayici_denetleyici

Overview:
- Sequences one shared 16-bit leading-zero counter (zero_counter_16: Z = leading zeros of a 16-bit half, V = all-zero flag) across two halves of a 32-bit operand.
- Provides CLZ and CTZ for the bit-manipulation/crypto unit (sifreleme_birimi) in the X-instruction execute stage.
- Valid/ready on input and output; supports pipeline flush.
- Saves area versus two counter instances, at the cost of 1–2 cycles of latency.

Parameters:
- ERKEN_BITIS, 1: 1 = finish after the upper half when that half is nonzero; 0 = always run both halves (fixed latency).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous, active-high reset
- bosalt_i  input  1  flush: abort the current operation and drop any pending result
- istek_gecerli_i  input  1  request valid
- istek_hazir_o  output  1  request ready; high only in BOSTA
- islem_i  input  1  0 = CLZ, 1 = CTZ
- deger_i  input  32  operand
- sonuc_gecerli_o  output  1  result valid
- sonuc_hazir_i  input  1  downstream ready
- sonuc_o  output  32  count, 0..32, zero-extended

Behaviour:
- Request accept: istek_gecerli_i & istek_hazir_o on a rising edge. On accept, latch the operand into islem_r:
  - CLZ: operand as-is.
  - CTZ: bit-reversed operand (bit i -> bit 31-i).
- One internal zero_counter_16 instance. Its input mux selects:
  - islem_r[31:16] in state UST.
  - islem_r[15:0] in state ALT.
- Half count: y = V ? 16 : Z (5 bits). V=1 with Z=15 means 16, never 15.
- States (reset -> BOSTA):
  - BOSTA: istek_hazir_o=1. Accept -> UST.
  - UST: compute y_ust, store it in ust_r.
    - If y_ust < 16 and ERKEN_BITIS=1: sonuc_r = y_ust -> SONUC.
    - Otherwise -> ALT.
  - ALT: compute y_alt.
    - If ust_r < 16 (only reachable with ERKEN_BITIS=0): sonuc_r = ust_r.
    - Otherwise: sonuc_r = 16 + y_alt (range 16..32).
    - -> SONUC.
  - SONUC: sonuc_gecerli_o=1 and sonuc_o is held stable. On sonuc_hazir_i=1 -> BOSTA.
- No back-to-back accept:
  - The next request is accepted no earlier than the cycle after the result handshake.
  - Maximum throughput is one result per 3 cycles.
- Latency, from the accept edge to the first cycle with sonuc_gecerli_o high:
  - 2 cycles with early finish.
  - 3 cycles with the lower half.
  - ERKEN_BITIS=0: always 3.
- Result selection is registered. sonuc_o and sonuc_gecerli_o come only from flops; no combinational path from the inputs.
- Reset values: state BOSTA, istek_hazir_o=1, sonuc_gecerli_o=0, sonuc_o=0, internal registers 0.
- Reset has priority over bosalt_i. bosalt_i has priority over every transition.
- bosalt_i in any state:
  - Next state is BOSTA and sonuc_gecerli_o=0 next cycle.
  - Any result not yet handshaken is discarded.
  - A request presented in the same cycle as bosalt_i is not accepted.
- Reset or flush mid-operation: no partial result is ever emitted. sonuc_o returns to 0 only on reset; after a flush it may retain stale data while valid is low.
- sonuc_hazir_i held low in SONUC: stall indefinitely with the output stable.
- istek_gecerli_i is ignored outside BOSTA.
- Operand 0:
  - CLZ = 32, CTZ = 32.
  - Both halves report V=1.
  - Never early-finishes.
- Width rule: the sum is at most 32 and fits in 6 bits; the upper 26 bits of sonuc_o are always 0.

Test Plan:
- Reset with rst_i=1 for 2 cycles:
  - During reset and the cycle after: sonuc_gecerli_o=0, istek_hazir_o=1, sonuc_o=0.
- CLZ 0x0001_0000, ERKEN_BITIS=1, sonuc_hazir_i=1:
  - sonuc_o=15.
  - Valid 2 cycles after accept.
  - istek_hazir_o low for those cycles.
- CLZ 0x0000_0001 -> 31, latency 3. CLZ 0x0000_0000 -> 32, latency 3. CLZ 0x8000_0000 -> 0, latency 2.
- CTZ 0x0000_0008 -> 3. CTZ 0x8000_0000 -> 31. CTZ 0 -> 32.
  - With ERKEN_BITIS=0, every case has latency 3 and the same values.
- Backpressure on CLZ 0x00F0_0000 (result 8):
  - Hold sonuc_hazir_i=0 for 5 cycles: sonuc_o stays 8, valid stays 1, istek_hazir_o stays 0.
  - Then raise sonuc_hazir_i for one cycle: valid drops, istek_hazir_o=1.
  - A second request is accepted that next cycle.
- Flush:
  - Pulse bosalt_i in UST: no result follows, and a new CLZ 0xFFFF_FFFF request then yields 0.
  - Pulse bosalt_i in SONUC while sonuc_hazir_i=0: valid drops the next cycle.
  - Assert bosalt_i together with istek_gecerli_i: the request is not accepted.

Source files
------------

// File: rtl/sifir_sayici_denetleyici_if.sv
// Request/result bundle for the shared leading-zero counter sequencer.
// Request side: istek_gecerli_i/istek_hazir_o handshake, islem_i (0=CLZ, 1=CTZ), deger_i operand.
// Result side: sonuc_gecerli_o/sonuc_hazir_i handshake, sonuc_o count (0..32, zero-extended).
interface sifir_sayici_denetleyici_if;
  logic        istek_gecerli_i;
  logic        istek_hazir_o;
  logic        islem_i;
  logic [31:0] deger_i;
  logic        sonuc_gecerli_o;
  logic        sonuc_hazir_i;
  logic [31:0] sonuc_o;

  // Requester / result consumer side
  modport master (
    output istek_gecerli_i, islem_i, deger_i, sonuc_hazir_i,
    input  istek_hazir_o, sonuc_gecerli_o, sonuc_o
  );

  // Counter sequencer side
  modport slave (
    input  istek_gecerli_i, islem_i, deger_i, sonuc_hazir_i,
    output istek_hazir_o, sonuc_gecerli_o, sonuc_o
  );
endinterface

// File: rtl/sifir_sayici_denetleyici.sv
// CLZ/CTZ of a 32-bit operand using one 16-bit zero counter over two halves.
// Latency: 2 cycles when the upper half decides (ERKEN_BITIS=1), else 3; one result per 3 cycles max.
// Backpressure: result held stable while sonuc_hazir_i is low; requests taken only in BOSTA.
// Ports: clk_i, rst_i (sync, active-high), bosalt_i (flush), bus (slave modport of the
// request/result interface).
module sifir_sayici_denetleyici #(
  parameter bit ERKEN_BITIS = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       bosalt_i,
  sifir_sayici_denetleyici_if.slave  bus
);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    UST   = 2'd1,
    ALT   = 2'd2,
    SONUC = 2'd3
  } durum_t;

  durum_t      durum_r, durum_n;
  logic [31:0] islem_r, islem_n;
  logic [4:0]  ust_r, ust_n;
  logic [5:0]  sonuc_r, sonuc_n;
  logic        gecerli_r, gecerli_n;

  logic [31:0] ters_deger;
  logic [15:0] sayac_giris;
  logic [3:0]  sayac_z;
  logic        sayac_v;
  logic [4:0]  yarim;
  logic        kabul;

  // CTZ is computed as CLZ of the bit-reversed operand.
  always_comb begin
    ters_deger = '0;
    for (int i = 0; i < 32; i++) begin
      ters_deger[i] = bus.deger_i[31-i];
    end
  end

  // Single shared counter: upper half in UST, lower half in ALT.
  always_comb begin
    sayac_giris = (durum_r == ALT) ? islem_r[15:0] : islem_r[31:16];
  end

  always_comb begin : zero_counter_16
    sayac_z = 4'd15;
    sayac_v = (sayac_giris == 16'd0);
    // Ascending scan: the highest set bit is the last to write Z.
    for (int i = 0; i < 16; i++) begin
      if (sayac_giris[i]) begin
        sayac_z = 4'(15 - i);
      end
    end
  end

  // An all-zero half counts 16; Z alone saturates at 15 and must not be used then.
  always_comb begin
    yarim = sayac_v ? 5'd16 : {1'b0, sayac_z};
  end

  assign kabul = bus.istek_gecerli_i && (durum_r == BOSTA) && !bosalt_i;

  always_comb begin
    durum_n   = durum_r;
    islem_n   = islem_r;
    ust_n     = ust_r;
    sonuc_n   = sonuc_r;
    gecerli_n = gecerli_r;

    unique case (durum_r)
      BOSTA: begin
        if (kabul) begin
          islem_n = bus.islem_i ? ters_deger : bus.deger_i;
          durum_n = UST;
        end
      end
      UST: begin
        ust_n = yarim;
        // yarim[4] set means the upper half is all zero (count 16).
        if (ERKEN_BITIS && !yarim[4]) begin
          sonuc_n   = {1'b0, yarim};
          gecerli_n = 1'b1;
          durum_n   = SONUC;
        end else begin
          durum_n = ALT;
        end
      end
      ALT: begin
        if (!ust_r[4]) begin
          sonuc_n = {1'b0, ust_r};
        end else begin
          sonuc_n = 6'd16 + {1'b0, yarim};
        end
        gecerli_n = 1'b1;
        durum_n   = SONUC;
      end
      SONUC: begin
        if (bus.sonuc_hazir_i) begin
          gecerli_n = 1'b0;
          durum_n   = BOSTA;
        end
      end
      default: begin
        durum_n   = BOSTA;
        gecerli_n = 1'b0;
      end
    endcase

    // Flush overrides everything: back to idle, nothing emitted, stale data kept.
    if (bosalt_i) begin
      durum_n   = BOSTA;
      gecerli_n = 1'b0;
      islem_n   = islem_r;
      ust_n     = ust_r;
      sonuc_n   = sonuc_r;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_r   <= BOSTA;
      islem_r   <= '0;
      ust_r     <= '0;
      sonuc_r   <= '0;
      gecerli_r <= 1'b0;
    end else begin
      durum_r   <= durum_n;
      islem_r   <= islem_n;
      ust_r     <= ust_n;
      sonuc_r   <= sonuc_n;
      gecerli_r <= gecerli_n;
    end
  end

  assign bus.istek_hazir_o   = (durum_r == BOSTA);
  assign bus.sonuc_gecerli_o = gecerli_r;
  assign bus.sonuc_o         = {26'd0, sonuc_r};

endmodule

// File: tb/tb_sifir_sayici_denetleyici.sv
// Bench for sifir_sayici_denetleyici: one instance with early finish, one without.
// Expected {latency, value} pairs are queued at issue; a negedge monitor pops and compares.
module tb_sifir_sayici_denetleyici;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic bosalt0, bosalt1;

  sifir_sayici_denetleyici_if ifc0();
  sifir_sayici_denetleyici_if ifc1();

  sifir_sayici_denetleyici #(.ERKEN_BITIS(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bosalt_i(bosalt0), .bus(ifc0)
  );
  sifir_sayici_denetleyici #(.ERKEN_BITIS(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bosalt_i(bosalt1), .bus(ifc1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc0 = 0;
  int acc1 = 0;

  logic [39:0] q0[$];
  logic [39:0] q1[$];
  logic        shown [2];
  logic [31:0] held [2];

  typedef struct {
    logic        op;
    logic [31:0] d;
    logic [31:0] v;
    int          lat1;
  } vec_t;
  vec_t tbl [0:9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic logic out_vld(input int w);
    return (w == 0) ? ifc0.sonuc_gecerli_o : ifc1.sonuc_gecerli_o;
  endfunction

  function automatic logic out_rdy(input int w);
    return (w == 0) ? ifc0.sonuc_hazir_i : ifc1.sonuc_hazir_i;
  endfunction

  function automatic logic in_rdy(input int w);
    return (w == 0) ? ifc0.istek_hazir_o : ifc1.istek_hazir_o;
  endfunction

  task automatic set_req(input int w, input logic v, input logic op, input logic [31:0] d);
    if (w == 0) begin
      ifc0.istek_gecerli_i = v; ifc0.islem_i = op; ifc0.deger_i = d;
    end else begin
      ifc1.istek_gecerli_i = v; ifc1.islem_i = op; ifc1.deger_i = d;
    end
  endtask

  task automatic set_srdy(input int w, input logic r);
    if (w == 0) ifc0.sonuc_hazir_i = r;
    else        ifc1.sonuc_hazir_i = r;
  endtask

  task automatic push_exp(input int w, input logic [31:0] v, input int lat);
    if (w == 0) q0.push_back({lat[7:0], v});
    else        q1.push_back({lat[7:0], v});
  endtask

  // Accept timing: cycle index in which the accepted request was presented.
  always @(posedge clk) begin
    if (!rst && !bosalt0 && ifc0.istek_gecerli_i && ifc0.istek_hazir_o) acc0 = cyc;
    if (!rst && !bosalt1 && ifc1.istek_gecerli_i && ifc1.istek_hazir_o) acc1 = cyc;
    cyc = cyc + 1;
  end

  task automatic mon(input int w, input logic vld, input logic hz,
                     input logic [31:0] s, input int lat);
    logic [39:0] e;
    logic        empty;
    if (vld) begin
      if (!shown[w]) begin
        shown[w] = 1'b1;
        held[w]  = s;
        empty = (w == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result dut%0d: got %0d expected none", w, s);
        end else begin
          if (w == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("sonuc dut%0d", w), s, e[31:0]);
          chk($sformatf("latency dut%0d", w), lat, {24'd0, e[39:32]});
        end
      end else begin
        chk($sformatf("hold dut%0d", w), s, held[w]);
      end
      if (hz) shown[w] = 1'b0;
    end else begin
      shown[w] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, ifc0.sonuc_gecerli_o, ifc0.sonuc_hazir_i, ifc0.sonuc_o, cyc - acc0);
      mon(1, ifc1.sonuc_gecerli_o, ifc1.sonuc_hazir_i, ifc1.sonuc_o, cyc - acc1);
    end
  end

  // Present a request and return at posedge+1 just after its accept edge.
  task automatic issue(input int w, input logic op, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    set_req(w, 1'b1, op, d);
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      ok = in_rdy(w);
      @(posedge clk);
      #1;
    end
    set_req(w, 1'b0, 1'b0, 32'd0);
    if (!ok) fail($sformatf("accept_timeout dut%0d", w));
  endtask

  task automatic wait_vld(input int w);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      ok = out_vld(w);
    end
    if (!ok) fail($sformatf("valid_timeout dut%0d", w));
  endtask

  task automatic wait_done(input int w);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      ok = out_vld(w) && out_rdy(w);
    end
    if (!ok) fail($sformatf("result_timeout dut%0d", w));
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int w, input logic op, input logic [31:0] d,
                     input logic [31:0] v, input int lat);
    set_srdy(w, 1'b1);
    push_exp(w, v, lat);
    issue(w, op, d);
    wait_done(w);
  endtask

  initial begin
    rst = 1'b1;
    bosalt0 = 1'b0;
    bosalt1 = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0);
    set_srdy(0, 1'b1);
    set_srdy(1, 1'b1);
    shown[0] = 1'b0; shown[1] = 1'b0;
    held[0] = '0;    held[1] = '0;

    tbl[0] = '{1'b0, 32'h0001_0000, 32'd15, 2};
    tbl[1] = '{1'b0, 32'h0000_0001, 32'd31, 3};
    tbl[2] = '{1'b0, 32'h0000_0000, 32'd32, 3};
    tbl[3] = '{1'b0, 32'h8000_0000, 32'd0,  2};
    tbl[4] = '{1'b1, 32'h0000_0008, 32'd3,  2};
    tbl[5] = '{1'b1, 32'h8000_0000, 32'd31, 3};
    tbl[6] = '{1'b1, 32'h0000_0000, 32'd32, 3};
    tbl[7] = '{1'b1, 32'h0001_0000, 32'd16, 3};
    tbl[8] = '{1'b0, 32'h0000_8000, 32'd16, 3};
    tbl[9] = '{1'b0, 32'h00F0_0000, 32'd8,  2};

    // Reset: two edges with rst high, then the cycle after release.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("reset_valid dut1", {31'd0, ifc1.sonuc_gecerli_o}, 32'd0);
      chk("reset_ready dut1", {31'd0, ifc1.istek_hazir_o}, 32'd1);
      chk("reset_sonuc dut1", ifc1.sonuc_o, 32'd0);
      chk("reset_valid dut0", {31'd0, ifc0.sonuc_gecerli_o}, 32'd0);
      chk("reset_ready dut0", {31'd0, ifc0.istek_hazir_o}, 32'd1);
      chk("reset_sonuc dut0", ifc0.sonuc_o, 32'd0);
      @(posedge clk);
      #1;
      if (r == 1) rst = 1'b0;
    end

    // Directed vectors on both instances; the fixed-latency one is always 3.
    for (int i = 0; i < 10; i++) begin
      run(1, tbl[i].op, tbl[i].d, tbl[i].v, tbl[i].lat1);
      run(0, tbl[i].op, tbl[i].d, tbl[i].v, 3);
    end

    // Backpressure: result 8 held for 5 cycles, then a single-cycle ready.
    set_srdy(1, 1'b0);
    push_exp(1, 32'd8, 2);
    issue(1, 1'b0, 32'h00F0_0000);
    wait_vld(1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_sonuc", ifc1.sonuc_o, 32'd8);
      chk("bp_valid", {31'd0, ifc1.sonuc_gecerli_o}, 32'd1);
      chk("bp_ready", {31'd0, ifc1.istek_hazir_o}, 32'd0);
    end
    @(posedge clk);
    #1;
    set_srdy(1, 1'b1);
    @(posedge clk);
    #1;
    set_srdy(1, 1'b0);
    push_exp(1, 32'd31, 3);
    set_req(1, 1'b1, 1'b0, 32'h0000_0001);
    @(negedge clk);
    chk("bp_after_valid", {31'd0, ifc1.sonuc_gecerli_o}, 32'd0);
    chk("bp_after_ready", {31'd0, ifc1.istek_hazir_o}, 32'd1);
    @(posedge clk);
    #1;
    set_req(1, 1'b0, 1'b0, 32'd0);
    chk("bp_second_accepted", {31'd0, ifc1.istek_hazir_o}, 32'd0);
    set_srdy(1, 1'b1);
    wait_done(1);

    // Flush during UST: nothing emitted, then a fresh request works.
    issue(1, 1'b0, 32'h1234_5678);
    bosalt1 = 1'b1;
    @(posedge clk);
    #1;
    bosalt1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("flush_ust_no_valid", {31'd0, ifc1.sonuc_gecerli_o}, 32'd0);
    end
    @(posedge clk);
    #1;
    run(1, 1'b0, 32'hFFFF_FFFF, 32'd0, 2);

    // Flush during SONUC with downstream stalled.
    set_srdy(1, 1'b0);
    push_exp(1, 32'd0, 2);
    issue(1, 1'b0, 32'h8000_0000);
    wait_vld(1);
    @(posedge clk);
    #1;
    bosalt1 = 1'b1;
    @(negedge clk);
    chk("flush_sonuc_before", {31'd0, ifc1.sonuc_gecerli_o}, 32'd1);
    @(posedge clk);
    #1;
    bosalt1 = 1'b0;
    @(negedge clk);
    chk("flush_sonuc_valid", {31'd0, ifc1.sonuc_gecerli_o}, 32'd0);
    chk("flush_sonuc_ready", {31'd0, ifc1.istek_hazir_o}, 32'd1);
    @(posedge clk);
    #1;
    set_srdy(1, 1'b1);

    // Flush together with a request: the request is dropped.
    set_req(1, 1'b1, 1'b0, 32'h0000_0001);
    bosalt1 = 1'b1;
    @(posedge clk);
    #1;
    set_req(1, 1'b0, 1'b0, 32'd0);
    bosalt1 = 1'b0;
    @(negedge clk);
    chk("flush_req_not_accepted", {31'd0, ifc1.istek_hazir_o}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("flush_req_no_valid", {31'd0, ifc1.sonuc_gecerli_o}, 32'd0);
    end

    repeat (3) @(negedge clk);
    chk("queue_left dut0", q0.size(), 32'd0);
    chk("queue_left dut1", q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
